// File: rtl/parking_gate_controller.sv
// Purpose : entry/exit barrier sequencer; owns the free-spot mask, allocates the lowest free spot, frees spots on exit.
// Latency : a request sampled in IDLE at edge N gives response pulse, mask update and gate open in cycle N+1.
// Backpr. : one transaction in flight; requests are only sampled in IDLE, so a held request waits until the gate closes.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   entry_req                   car waiting at entry gate (level)
//   exit_req, exit_spot         car waiting at exit gate and the spot it vacates (level)
//   car_passed                  gate-line sensor, only looked at while a gate is open
//   free_mask, free_count, full free-spot bitmap (registered), its popcount and the lot-full flag
//   entry_grant, entry_spot     one-cycle grant pulse and the allocated spot (held between grants)
//   entry_deny                  one-cycle pulse: lot full
//   exit_ack, exit_err          one-cycle pulses: spot freed / spot was already free
//   gate_in_open, gate_out_open barrier drives
module parking_gate_controller #(
    parameter int NUM_SPOTS        = 8,
    parameter int GATE_OPEN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_spot,
    input  logic       car_passed,
    output logic [7:0] free_mask,
    output logic [3:0] free_count,
    output logic       full,
    output logic       entry_grant,
    output logic [2:0] entry_spot,
    output logic       entry_deny,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_in_open,
    output logic       gate_out_open
);

    localparam int TW = $clog2(GATE_OPEN_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(GATE_OPEN_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_OPEN  = 2'd1,
        OUT_OPEN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    mask_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    spot_nxt;
    logic          grant_nxt, deny_nxt, ack_nxt, err_nxt;
    logic [2:0]    low_idx;

    // Popcount of the mask; 4 bits covers 0..8.
    always_comb begin
        free_count = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            free_count = free_count + 4'(free_mask[i]);
        end
    end

    assign full = (free_count == 4'd0);

    // Lowest-index free spot; scanning downward lets the last hit win.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    assign gate_in_open  = (state == IN_OPEN);
    assign gate_out_open = (state == OUT_OPEN);

    always_comb begin
        state_nxt = state;
        mask_nxt  = free_mask;
        timer_nxt = '0;
        spot_nxt  = entry_spot;
        grant_nxt = 1'b0;
        deny_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                // Exit wins: it frees capacity. An invalid exit still
                // blocks entry for this cycle.
                if (exit_req) begin
                    if (!free_mask[exit_spot]) begin
                        mask_nxt[exit_spot] = 1'b1;
                        ack_nxt             = 1'b1;
                        state_nxt           = OUT_OPEN;
                        timer_nxt           = TW'(1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (entry_req) begin
                    if (!full) begin
                        mask_nxt[low_idx] = 1'b0;
                        spot_nxt          = low_idx;
                        grant_nxt         = 1'b1;
                        state_nxt         = IN_OPEN;
                        timer_nxt         = TW'(1);
                    end else begin
                        deny_nxt = 1'b1;
                    end
                end
            end

            IN_OPEN: begin
                if (car_passed || timer == TIMER_MAX) begin
                    state_nxt = IDLE;
                    // Timeout without a pass: the car never entered, so
                    // hand its spot back on the same edge the gate drops.
                    if (!car_passed) begin
                        mask_nxt[entry_spot] = 1'b1;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end

            OUT_OPEN: begin
                if (car_passed || timer == TIMER_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            free_mask   <= 8'hFF;
            timer       <= '0;
            entry_spot  <= '0;
            entry_grant <= 1'b0;
            entry_deny  <= 1'b0;
            exit_ack    <= 1'b0;
            exit_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            free_mask   <= mask_nxt;
            timer       <= timer_nxt;
            entry_spot  <= spot_nxt;
            entry_grant <= grant_nxt;
            entry_deny  <= deny_nxt;
            exit_ack    <= ack_nxt;
            exit_err    <= err_nxt;
        end
    end

endmodule
